// File: rtl/kmeans_iter_ctrl.sv
// K-means iteration sequencer: clears the cluster engine, streams the pixel RAM through it,
// then divides the per-cluster sums by their counts to get new means, until they settle.
module kmeans_iter_ctrl #(
    parameter int unsigned K       = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned CNT_W   = ADDR_W + 1,
    parameter int unsigned ACC_W   = 8 + CNT_W,
    parameter int unsigned ENG_LAT = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [ADDR_W:0]        i_num_pixels,
    input  logic [7:0]             i_max_iter,
    input  logic [24*K-1:0]        i_init_means,
    input  logic [K-1:0]           i_init_enabled,
    output logic [ADDR_W-1:0]      o_pix_addr,
    output logic                   o_pix_rd,
    input  logic [23:0]            i_pix_data,
    output logic                   o_eng_clear,
    output logic [23:0]            o_eng_pixel,
    output logic                   o_eng_pix_valid,
    output logic [24*K-1:0]        o_eng_mean,
    output logic [K-1:0]           o_eng_enabled,
    input  logic [3*ACC_W*K-1:0]   i_eng_acc,
    input  logic [CNT_W*K-1:0]     i_eng_cnt,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_converged,
    output logic [7:0]             o_iter_count
);

    localparam int unsigned CluW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CluW-1:0] LastClu = CluW'(K - 1);
    localparam logic [7:0] DrainLast = 8'(ENG_LAT);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StLoad,
        StDiv,
        StCheck,
        StDone
    } state_t;

    state_t r_state, w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last;
    logic [7:0]        r_max;
    logic [7:0]        r_iter;
    logic [24*K-1:0]   r_mean;
    logic [24*K-1:0]   r_shadow;
    logic [K-1:0]      r_en;
    logic              r_conv;
    logic              r_pix_vld;
    logic [7:0]        r_drain;
    logic [CluW-1:0]   r_clu;
    logic [1:0]        r_ch;
    logic [2:0]        r_bit;
    logic [ACC_W-1:0]  r_rem;
    logic [7:0]        r_quot;
    logic [CNT_W-1:0]  r_div;

    logic [ADDR_W-1:0] w_last;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_skip;
    logic              w_last_clu;
    logic              w_changed;
    logic [7:0]        w_iter_inc;
    logic [ACC_W-1:0]  w_dshift;
    logic              w_ge;
    logic [7:0]        w_q;
    logic [1:0]        w_ch_next;
    logic [ACC_W-1:0]  w_acc_first;
    logic [ACC_W-1:0]  w_acc_next;
    int                w_clu_base;
    int                w_byte_lo;

    always_comb begin
        w_last      = ADDR_W'(i_num_pixels - 1'b1);
        w_clu_base  = int'(r_clu);
        w_cnt       = i_eng_cnt[w_clu_base*CNT_W +: CNT_W];
        w_skip      = !r_en[r_clu] || (w_cnt == '0);
        w_last_clu  = (r_clu == LastClu);
        w_changed   = (r_shadow != r_mean);
        w_iter_inc  = (r_iter == 8'hFF) ? r_iter : r_iter + 8'd1;
        // Restoring step: compare the remainder against divisor * 2^bit.
        w_dshift    = ACC_W'(r_div) << r_bit;
        w_ge        = (r_rem >= w_dshift);
        w_q         = r_quot | (8'(w_ge) << r_bit);
        w_ch_next   = (r_ch == 2'd2) ? 2'd0 : r_ch + 2'd1;
        // Accumulators are packed {R,G,B} per cluster, R in the top slice.
        w_acc_first = i_eng_acc[(3*w_clu_base + 2)*ACC_W +: ACC_W];
        w_acc_next  = i_eng_acc[(3*w_clu_base + 2 - int'(w_ch_next))*ACC_W +: ACC_W];
        w_byte_lo   = w_clu_base*24 + 16 - 8*int'(r_ch);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_pix_rd     = 1'b0;
        o_eng_clear  = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = (i_num_pixels == '0) ? StDone : StClear;
                end
            end
            StClear: begin
                o_busy       = 1'b1;
                o_eng_clear  = 1'b1;
                w_state_next = StStream;
            end
            StStream: begin
                o_busy   = 1'b1;
                o_pix_rd = 1'b1;
                if (r_addr == r_last) w_state_next = StDrain;
            end
            StDrain: begin
                o_busy = 1'b1;
                if (r_drain == DrainLast) w_state_next = StLoad;
            end
            StLoad: begin
                o_busy = 1'b1;
                if (!w_skip) w_state_next = StDiv;
                else if (w_last_clu) w_state_next = StCheck;
            end
            StDiv: begin
                o_busy = 1'b1;
                if (r_bit == 3'd0 && r_ch == 2'd2) begin
                    w_state_next = w_last_clu ? StCheck : StLoad;
                end
            end
            StCheck: begin
                o_busy = 1'b1;
                if (!w_changed || w_iter_inc >= r_max) w_state_next = StDone;
                else w_state_next = StClear;
            end
            StDone: begin
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr    <= '0;
            r_last    <= '0;
            r_max     <= 8'd1;
            r_iter    <= '0;
            r_mean    <= '0;
            r_shadow  <= '0;
            r_en      <= '0;
            r_conv    <= 1'b0;
            r_pix_vld <= 1'b0;
            r_drain   <= '0;
            r_clu     <= '0;
            r_ch      <= '0;
            r_bit     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_div     <= '0;
        end else begin
            r_pix_vld <= (r_state == StStream);
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_mean <= i_init_means;
                        r_en   <= i_init_enabled;
                        r_last <= w_last;
                        r_max  <= (i_max_iter == 8'd0) ? 8'd1 : i_max_iter;
                        r_iter <= '0;
                        r_conv <= (i_num_pixels == '0);
                        r_addr <= '0;
                    end
                end
                StClear: begin
                    r_addr  <= '0;
                    r_drain <= '0;
                    r_clu   <= '0;
                end
                StStream: begin
                    if (r_addr != r_last) r_addr <= r_addr + 1'b1;
                end
                StDrain: r_drain <= r_drain + 8'd1;
                StLoad: begin
                    if (w_skip) begin
                        r_shadow[w_clu_base*24 +: 24] <= r_mean[w_clu_base*24 +: 24];
                        r_clu <= r_clu + 1'b1;
                    end else begin
                        r_div  <= w_cnt;
                        r_rem  <= w_acc_first;
                        r_bit  <= 3'd7;
                        r_ch   <= 2'd0;
                        r_quot <= '0;
                    end
                end
                StDiv: begin
                    r_bit  <= r_bit - 3'd1;
                    r_quot <= w_q;
                    if (w_ge) r_rem <= r_rem - w_dshift;
                    if (r_bit == 3'd0) begin
                        r_shadow[w_byte_lo +: 8] <= w_q;
                        r_quot <= '0;
                        if (r_ch == 2'd2) begin
                            r_clu <= r_clu + 1'b1;
                        end else begin
                            r_ch  <= w_ch_next;
                            r_rem <= w_acc_next;
                        end
                    end
                end
                StCheck: begin
                    r_mean <= r_shadow;
                    r_iter <= w_iter_inc;
                    if (!w_changed || w_iter_inc >= r_max) r_conv <= !w_changed;
                end
                default: ;
            endcase
        end
    end

    assign o_pix_addr      = r_addr;
    assign o_eng_pix_valid = r_pix_vld;
    assign o_eng_pixel     = r_pix_vld ? i_pix_data : 24'd0;
    assign o_eng_mean      = r_mean;
    assign o_eng_enabled   = r_en;
    assign o_converged     = r_conv;
    assign o_iter_count    = r_iter;

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Bench for kmeans_iter_ctrl: pixel RAM and nearest-mean cluster engine models, directed jobs,
// and a done-triggered scoreboard monitor.
module tb_kmeans_iter_ctrl;
    localparam int K = 16, ADDR_W = 16, CNT_W = 17, ACC_W = 25, MW = 24*K;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [ADDR_W:0]   num_pixels = '0;
    logic [7:0]        max_iter = '0;
    logic [MW-1:0]     init_means = '0;
    logic [K-1:0]      init_enabled = '0;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_rd, eng_clear, eng_pix_valid, busy, done, converged;
    logic [23:0]       pix_data = '0, eng_pixel;
    logic [MW-1:0]     eng_mean;
    logic [K-1:0]      eng_enabled;
    logic [3*ACC_W*K-1:0] eng_acc = '0;
    logic [CNT_W*K-1:0]   eng_cnt = '0;
    logic [7:0]        iter_count;

    kmeans_iter_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_pixels(num_pixels),
        .i_max_iter(max_iter), .i_init_means(init_means), .i_init_enabled(init_enabled),
        .o_pix_addr(pix_addr), .o_pix_rd(pix_rd), .i_pix_data(pix_data),
        .o_eng_clear(eng_clear), .o_eng_pixel(eng_pixel), .o_eng_pix_valid(eng_pix_valid),
        .o_eng_mean(eng_mean), .o_eng_enabled(eng_enabled), .i_eng_acc(eng_acc),
        .i_eng_cnt(eng_cnt), .o_busy(busy), .o_done(done), .o_converged(converged),
        .o_iter_count(iter_count)
    );

    always #5 clk = ~clk;

    logic [23:0] pix_mem [16];
    always @(posedge clk) if (pix_rd) pix_data <= pix_mem[pix_addr[3:0]];

    function automatic int nearest(logic [23:0] p, logic [MW-1:0] m, logic [K-1:0] en);
        int best = 0, bd = -1;
        for (int i = 0; i < K; i++) begin
            int dr, dg, db, d;
            dr = int'(p[23:16]) - int'(m[i*24+16 +: 8]);
            dg = int'(p[15:8]) - int'(m[i*24+8 +: 8]);
            db = int'(p[7:0]) - int'(m[i*24 +: 8]);
            d = dr*dr + dg*dg + db*db;
            if (en[i] && (bd < 0 || d < bd)) begin bd = d; best = i; end
        end
        return best;
    endfunction

    int best;
    always_comb best = nearest(eng_pixel, eng_mean, eng_enabled);

    // Engine model with one cycle of latency from eng_pix_valid.
    always @(posedge clk) begin
        if (eng_clear) begin
            eng_acc <= '0;
            eng_cnt <= '0;
        end else if (eng_pix_valid) begin
            eng_acc[(3*best+2)*ACC_W +: ACC_W] <= eng_acc[(3*best+2)*ACC_W +: ACC_W] + ACC_W'(eng_pixel[23:16]);
            eng_acc[(3*best+1)*ACC_W +: ACC_W] <= eng_acc[(3*best+1)*ACC_W +: ACC_W] + ACC_W'(eng_pixel[15:8]);
            eng_acc[(3*best)*ACC_W +: ACC_W]   <= eng_acc[(3*best)*ACC_W +: ACC_W] + ACC_W'(eng_pixel[7:0]);
            eng_cnt[best*CNT_W +: CNT_W]       <= eng_cnt[best*CNT_W +: CNT_W] + 1'b1;
        end
    end

    typedef struct {
        logic          conv;
        logic [7:0]    iter;
        logic [MW-1:0] means;
        int            nvalid;
        int            nclear;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic exp_t mk(logic c, int it, logic [MW-1:0] m, int nv, int nc);
        exp_t e;
        e.conv = c; e.iter = 8'(it); e.means = m; e.nvalid = nv; e.nclear = nc;
        return e;
    endfunction

    // Monitor: counts engine traffic per job and checks results whenever done pulses.
    int cnt_valid = 0, cnt_clear = 0, cnt_rd = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt_valid = 0; cnt_clear = 0; cnt_rd = 0;
            end else begin
                if (eng_pix_valid) cnt_valid++;
                if (eng_clear) cnt_clear++;
                if (pix_rd) cnt_rd++;
                if (done) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_done: got done=1 expected no pending job");
                    end else begin
                        e = sb.pop_front();
                        chk("converged", MW'(converged), MW'(e.conv));
                        chk("iter_count", MW'(iter_count), MW'(e.iter));
                        chk("means", eng_mean, e.means);
                        chk("pix_valid_count", MW'(cnt_valid), MW'(e.nvalid));
                        chk("pix_rd_count", MW'(cnt_rd), MW'(e.nvalid));
                        chk("clear_count", MW'(cnt_clear), MW'(e.nclear));
                        chk("busy_at_done", MW'(busy), '0);
                    end
                    cnt_valid = 0; cnt_clear = 0; cnt_rd = 0;
                end
            end
        end
    end

    task automatic run_job(input int np, input logic [7:0] mi, input logic [MW-1:0] m,
                           input logic [K-1:0] en, input exp_t e, input bit extra_start,
                           output int cyc);
        num_pixels = (ADDR_W+1)'(np); max_iter = mi; init_means = m; init_enabled = en;
        @(posedge clk); #1 start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1 start = 1'b0;
        cyc = 1;
        if (extra_start) begin
            int w;
            for (w = 0; w < 100; w++) begin @(negedge clk); cyc++; if (pix_rd) break; end
            if (w == 100) begin n_checks++; $display("FAIL stream_wait: got no pix_rd expected stream"); end
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done) break;
            cyc++;
        end
        if (!done) begin n_checks++; $display("FAIL done_timeout: got no done expected done"); end
        repeat (3) @(negedge clk);
        chk("mean_hold", eng_mean, e.means);
    endtask

    function automatic logic [MW-1:0] base_means();
        logic [MW-1:0] m;
        for (int i = 0; i < K; i++) m[i*24 +: 24] = 24'h102030 + 24'(i);
        return m;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [MW-1:0] m1, e1, m3, e3, m7, e7;
        int cyc;

        #3;
        chk("reset_ctrl", MW'({busy, done, converged, pix_rd, eng_clear, eng_pix_valid}), '0);
        chk("reset_data", MW'({pix_addr, eng_pixel, eng_enabled, iter_count}), '0);
        chk("reset_mean", eng_mean, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        m1 = base_means(); m1[0 +: 24] = 24'h000000; m1[15*24 +: 24] = 24'hFFFFFF;
        e1 = m1; e1[0 +: 24] = 24'h0F0F0F; e1[15*24 +: 24] = 24'hF5F5F5;
        pix_mem[0] = 24'h0A0A0A; pix_mem[1] = 24'h141414;
        pix_mem[2] = 24'hF0F0F0; pix_mem[3] = 24'hFAFAFA;

        // Two gray clusters: settles after the second pass.
        run_job(4, 8'd8, m1, 16'h8001, mk(1'b1, 2, e1, 8, 2), 1'b0, cyc);
        // Iteration limit reached while means still moving.
        run_job(4, 8'd1, m1, 16'h8001, mk(1'b0, 1, e1, 4, 1), 1'b0, cyc);
        // max_iter of zero behaves as one.
        run_job(4, 8'd0, m1, 16'h8001, mk(1'b0, 1, e1, 4, 1), 1'b0, cyc);

        // Truncation 32/3 = 10; enabled c1 gets no pixels and keeps its mean.
        pix_mem[0] = 24'h0A0A0A; pix_mem[1] = 24'h0B0B0B; pix_mem[2] = 24'h0B0B0B;
        m3 = base_means(); m3[0 +: 24] = 24'h000000; m3[24 +: 24] = 24'hFFFFFF;
        e3 = m3; e3[0 +: 24] = 24'h0A0A0A;
        run_job(3, 8'd8, m3, 16'h0003, mk(1'b1, 2, e3, 6, 2), 1'b0, cyc);

        // Distinct channels: R=40/2, G=80/2, B=121/2.
        pix_mem[0] = 24'h1E3C5A; pix_mem[1] = 24'h0A141F;
        m7 = base_means(); m7[0 +: 24] = 24'h000000;
        e7 = m7; e7[0 +: 24] = 24'h14283C;
        run_job(2, 8'd8, m7, 16'h0001, mk(1'b1, 2, e7, 4, 2), 1'b0, cyc);

        // Empty image finishes immediately.
        run_job(0, 8'd8, m7, 16'h0001, mk(1'b1, 0, m7, 0, 0), 1'b0, cyc);
        chk("zero_px_latency", MW'(cyc <= 2), MW'(1));

        // Abort mid-stream with reset.
        pix_mem[0] = 24'h0A0A0A; pix_mem[1] = 24'h141414;
        pix_mem[2] = 24'hF0F0F0; pix_mem[3] = 24'hFAFAFA;
        num_pixels = 17'd4; max_iter = 8'd8; init_means = m1; init_enabled = 16'h8001;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        begin
            int w;
            for (w = 0; w < 100; w++) begin @(negedge clk); if (pix_rd && pix_addr == 16'd1) break; end
            if (w == 100) begin n_checks++; $display("FAIL abort_wait: got no stream expected stream"); end
        end
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ctrl", MW'({busy, done, converged, pix_rd, eng_clear, eng_pix_valid}), '0);
        chk("abort_data", MW'({pix_addr, eng_pixel, eng_enabled, iter_count}), '0);
        chk("abort_mean", eng_mean, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);

        run_job(4, 8'd8, m1, 16'h8001, mk(1'b1, 2, e1, 8, 2), 1'b0, cyc);
        // Second start during streaming must be ignored.
        run_job(4, 8'd8, m1, 16'h8001, mk(1'b1, 2, e1, 8, 2), 1'b1, cyc);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
